vc_fifo: RTL and testbench

Multi-channel input buffer for a router input port. It holds NUM_VC independent circular FIFOs of DEPTH flits each, all in one storage array. It accepts one flit write and one flit read per cycle, and each may target any VC. Per-VC empty, full and packet-space (ordy) flags drive the upstream credit logic and the switch allocator.

---
 rtl/noc_pkg.sv | 17 +
 rtl/vc_fifo_ctrl.sv | 51 +++++
 rtl/vc_fifo.sv | 104 ++++++++++
 tb/tb_vc_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared router defaults (flit width, VC count, packet length),
// the VC index width helper and the flit type.
// Imported by vc_fifo and vc_fifo_ctrl.
package noc_pkg;

  localparam int DATA_W_DEF  = 33;
  localparam int NUM_VC_DEF  = 4;
  localparam int PKT_LEN_DEF = 4;

  // A single VC still needs a 1-bit select so the port never collapses to 0 bits.
  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [DATA_W_DEF-1:0] flit_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer and occupancy bookkeeping for one virtual channel.
// Latency: pointers and cnt update on the edge after push/pop; flags are combinational from cnt.
// Backpressure: none internally; the caller only asserts push/pop once it has accepted them.
// Ports: clk, rst (sync, active-high), push, pop, rd_ptr/wr_ptr (storage offsets), empty, full, ordy.
module vc_fifo_ctrl
  import noc_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int PKT_LEN = PKT_LEN_DEF,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic          empty,
  output logic          full,
  output logic          ordy
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_C    = CW'(PKT_LEN);

  logic [CW-1:0] cnt;
  logic [CW-1:0] free_slots;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Explicit wrap: DEPTH need not be a power of two.
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // cnt never exceeds DEPTH, so this subtraction cannot underflow.
  assign free_slots = CNT_MAX - cnt;
  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_MAX);
  assign ordy       = (free_slots >= PKT_C);

endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC circular flit FIFOs of DEPTH entries sharing one storage array.
// Latency: write visible on rd_data one cycle later; first-word fall-through, no output register.
// Backpressure: writes to a full VC (without a same-VC pop) are dropped, reads of an empty VC ignored.
// Ports: clk, rst (sync, active-high), wr_en/wr_vc/wr_data, rd_en/rd_vc, rd_data,
//        per-VC empty/full/ordy, and sticky wr_err/rd_err when VC_FIFO_ERR_EN is defined.
module vc_fifo
  import noc_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int NUM_VC  = NUM_VC_DEF,
  parameter  int DEPTH   = 8,
  parameter  int PKT_LEN = PKT_LEN_DEF,
  localparam int VC_W    = vc_w(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [VC_W-1:0]   wr_vc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [VC_W-1:0]   rd_vc,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_VC-1:0] empty,
  output logic [NUM_VC-1:0] full,
  output logic [NUM_VC-1:0] ordy
`ifdef VC_FIFO_ERR_EN
  ,
  output logic              wr_err,
  output logic              rd_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(NUM_VC * DEPTH);

  logic [PW-1:0]     rd_ptr_a [NUM_VC];
  logic [PW-1:0]     wr_ptr_a [NUM_VC];
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;

  logic              rd_vc_ok, wr_vc_ok;
  logic              rd_empty;
  logic              rd_ok, wr_ok;
  logic [PW-1:0]     rd_ptr_sel, wr_ptr_sel;
  logic [AW-1:0]     rd_addr, wr_addr;

  logic [DATA_W-1:0] mem [NUM_VC * DEPTH];

  // Out-of-range VC indices behave like an empty (read) or full (write) VC.
  assign rd_vc_ok = ({1'b0, rd_vc} < (VC_W + 1)'(NUM_VC));
  assign wr_vc_ok = ({1'b0, wr_vc} < (VC_W + 1)'(NUM_VC));
  assign rd_empty = rd_vc_ok ? empty[rd_vc] : 1'b1;

  // Requests are ignored during the reset cycle.
  assign rd_ok = rd_en && !rd_empty && !rst;
  // A full VC can still take a write in the cycle it is popped.
  assign wr_ok = wr_en && wr_vc_ok && !rst &&
                 (!full[wr_vc] || (rd_ok && (rd_vc == wr_vc)));

  assign rd_ptr_sel = rd_vc_ok ? rd_ptr_a[rd_vc] : '0;
  assign wr_ptr_sel = wr_vc_ok ? wr_ptr_a[wr_vc] : '0;
  assign rd_addr    = AW'(int'(rd_vc) * DEPTH + int'(rd_ptr_sel));
  assign wr_addr    = AW'(int'(wr_vc) * DEPTH + int'(wr_ptr_sel));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = wr_ok && (wr_vc == VC_W'(v));
    assign pop[v]  = rd_ok && (rd_vc == VC_W'(v));

    vc_fifo_ctrl #(
      .DEPTH   (DEPTH),
      .PKT_LEN (PKT_LEN)
    ) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .push   (push[v]),
      .pop    (pop[v]),
      .rd_ptr (rd_ptr_a[v]),
      .wr_ptr (wr_ptr_a[v]),
      .empty  (empty[v]),
      .full   (full[v]),
      .ordy   (ordy[v])
    );
  end

  // Storage is never cleared; the empty gate on rd_data hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_empty ? '0 : mem[rd_addr];

`ifdef VC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) wr_err <= 1'b1;
      if (rd_en && !rd_ok) rd_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed checks of vc_fifo at DEPTH=8 (main instance) and DEPTH=5 (wrap instance).
module tb_vc_fifo;

  logic        clk = 1'b0;
  logic        rst;

  logic        wr_en, rd_en;
  logic [1:0]  wr_vc, rd_vc;
  logic [32:0] wr_data, rd_data;
  logic [3:0]  empty, full, ordy;

  logic        wr_en5, rd_en5;
  logic [1:0]  wr_vc5, rd_vc5;
  logic [32:0] wr_data5, rd_data5;
  logic [3:0]  empty5, full5, ordy5;

`ifdef VC_FIFO_ERR_EN
  logic wr_err, rd_err, wr_err5, rd_err5;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_fifo #(.DATA_W(33), .NUM_VC(4), .DEPTH(8), .PKT_LEN(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
    .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data),
    .empty(empty), .full(full), .ordy(ordy)
`ifdef VC_FIFO_ERR_EN
    , .wr_err(wr_err), .rd_err(rd_err)
`endif
  );

  vc_fifo #(.DATA_W(33), .NUM_VC(4), .DEPTH(5), .PKT_LEN(4)) u_dut5 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en5), .wr_vc(wr_vc5), .wr_data(wr_data5),
    .rd_en(rd_en5), .rd_vc(rd_vc5), .rd_data(rd_data5),
    .empty(empty5), .full(full5), .ordy(ordy5)
`ifdef VC_FIFO_ERR_EN
    , .wr_err(wr_err5), .rd_err(rd_err5)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic we, input logic [1:0] wv, input logic [32:0] wd,
                        input logic re, input logic [1:0] rv);
    wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv;
  endtask

  task automatic drive5(input logic we, input logic [32:0] wd, input logic re);
    wr_en5 = we; wr_vc5 = 2'd0; wr_data5 = wd; rd_en5 = re; rd_vc5 = 2'd0;
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive8(1'b1, 2'd2, 33'hAA, 1'b0, 2'd2);
    drive5(1'b1, 33'h55, 1'b0);

    // Reset with writes requested: none may be taken.
    tick(); tick();
    rst = 1'b0;
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd2);
    drive5(1'b0, 33'h0, 1'b0);
    #1;
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_full",  64'(full),  64'h0);
    chk("rst_ordy",  64'(ordy),  64'hF);
    chk("rst_rdata", 64'(rd_data), 64'h0);
    chk("rst_empty5", 64'(empty5), 64'hF);
`ifdef VC_FIFO_ERR_EN
    chk("rst_wr_err", 64'(wr_err), 64'h0);
    chk("rst_rd_err", 64'(rd_err), 64'h0);
`endif
    tick();
    chk("post_rst_empty", 64'(empty), 64'hF);

    // Fill VC2 with 1..8.
    for (int i = 1; i <= 8; i++) begin
      drive8(1'b1, 2'd2, 33'(i), 1'b0, 2'd2);
      tick();
      if (i == 4) chk("vc2_ordy_at4", 64'(ordy[2]), 64'h1);
      if (i == 5) chk("vc2_ordy_at5", 64'(ordy[2]), 64'h0);
      if (i == 7) chk("vc2_full_at7", 64'(full[2]), 64'h0);
    end
    chk("vc2_full_at8", 64'(full), 64'h4);
    chk("vc2_empty_at8", 64'(empty), 64'hB);
    // Ninth write must be dropped.
    drive8(1'b1, 2'd2, 33'h9, 1'b0, 2'd2);
    tick();
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd2);
    chk("vc2_full_drop", 64'(full[2]), 64'h1);
`ifdef VC_FIFO_ERR_EN
    chk("vc2_wr_err", 64'(wr_err), 64'h1);
`endif
    for (int i = 1; i <= 8; i++) begin
      drive8(1'b0, 2'd0, 33'h0, 1'b1, 2'd2);
      #1;
      chk($sformatf("vc2_rd%0d", i), 64'(rd_data), 64'(i));
      tick();
    end
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd2);
    #1;
    chk("vc2_drained_empty", 64'(empty), 64'hF);
    chk("vc2_drained_rdata", 64'(rd_data), 64'h0);

    // Full VC1: simultaneous pop and push.
    for (int i = 1; i <= 8; i++) begin
      drive8(1'b1, 2'd1, 33'(32'h10 + i), 1'b0, 2'd1);
      tick();
    end
    chk("vc1_full", 64'(full[1]), 64'h1);
    drive8(1'b1, 2'd1, 33'h19, 1'b1, 2'd1);
    #1;
    chk("vc1_pushpop_head", 64'(rd_data), 64'h11);
    tick();
    chk("vc1_pushpop_full", 64'(full[1]), 64'h1);
    for (int i = 2; i <= 9; i++) begin
      drive8(1'b0, 2'd0, 33'h0, 1'b1, 2'd1);
      #1;
      chk($sformatf("vc1_rd%0d", i), 64'(rd_data), 64'(32'h10 + i));
      tick();
    end
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd1);
    chk("vc1_drained_empty", 64'(empty[1]), 64'h1);
`ifdef VC_FIFO_ERR_EN
    chk("rd_err_still_clear", 64'(rd_err), 64'h0);
`endif

    // Cross-VC: VC3 holds 2, VC0 holds 4; then write VC0 while reading VC3.
    drive8(1'b1, 2'd3, 33'h31, 1'b0, 2'd3); tick();
    drive8(1'b1, 2'd3, 33'h32, 1'b0, 2'd3); tick();
    for (int i = 1; i <= 4; i++) begin
      drive8(1'b1, 2'd0, 33'(i), 1'b0, 2'd3);
      tick();
    end
    chk("vc0_ordy_at4", 64'(ordy[0]), 64'h1);
    drive8(1'b1, 2'd0, 33'h5, 1'b1, 2'd3);
    #1;
    chk("cross_rd_vc3", 64'(rd_data), 64'h31);
    tick();
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd3);
    chk("cross_ordy", 64'(ordy), 64'hE);
    chk("cross_empty", 64'(empty), 64'h6);
    chk("cross_full", 64'(full), 64'h0);
    drive8(1'b0, 2'd0, 33'h0, 1'b1, 2'd3);
    #1;
    chk("cross_rd_vc3_2", 64'(rd_data), 64'h32);
    tick();
    chk("cross_vc3_empty", 64'(empty[3]), 64'h1);
    for (int i = 1; i <= 5; i++) begin
      drive8(1'b0, 2'd0, 33'h0, 1'b1, 2'd0);
      #1;
      chk($sformatf("vc0_rd%0d", i), 64'(rd_data), 64'(i));
      tick();
    end
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd0);
    chk("all_empty", 64'(empty), 64'hF);

    // Empty read on VC1.
    drive8(1'b0, 2'd0, 33'h0, 1'b1, 2'd1);
    #1;
    chk("empty_rd_rdata", 64'(rd_data), 64'h0);
    tick();
    chk("empty_rd_still_empty", 64'(empty[1]), 64'h1);
`ifdef VC_FIFO_ERR_EN
    chk("empty_rd_rd_err", 64'(rd_err), 64'h1);
`endif
    drive8(1'b1, 2'd1, 33'h77, 1'b0, 2'd1);
    tick();
    drive8(1'b0, 2'd0, 33'h0, 1'b0, 2'd1);
    #1;
    chk("after_empty_rd_head", 64'(rd_data), 64'h77);

    // DEPTH=5 wrap: 12 flits through VC0 with interleaved pops.
    drive5(1'b1, 33'hA1, 1'b0); tick();
    chk("d5_ordy_at1", 64'(ordy5[0]), 64'h1);
    drive5(1'b1, 33'hA2, 1'b0); tick();
    chk("d5_ordy_at2", 64'(ordy5[0]), 64'h0);
    drive5(1'b1, 33'hA3, 1'b0); tick();
    for (int k = 4; k <= 12; k++) begin
      drive5(1'b1, 33'(32'hA0 + k), 1'b1);
      #1;
      chk($sformatf("d5_stream_rd%0d", k - 3), 64'(rd_data5), 64'(32'hA0 + k - 3));
      tick();
    end
    for (int k = 10; k <= 12; k++) begin
      drive5(1'b0, 33'h0, 1'b1);
      #1;
      chk($sformatf("d5_drain_rd%0d", k), 64'(rd_data5), 64'(32'hA0 + k));
      tick();
    end
    drive5(1'b0, 33'h0, 1'b0);
    chk("d5_empty", 64'(empty5), 64'hF);
    chk("d5_full", 64'(full5), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
